// File: rtl/wishbone_classic_stream_reader_pkg.sv
// Shared definitions for the Wishbone classic stream reader: cycle-type
// tags, burst-type constant, FSM state encoding and a ceil-log2 helper.
package wishbone_classic_stream_reader_pkg;

  // Wishbone cycle-type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  // Linear burst type; this master never wraps bursts
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for values of 0 or 1
  function automatic int clogb2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wishbone_classic_stream_reader.sv
// Wishbone classic read master: fetches a block of consecutive words one
// single-beat read at a time and hands each word out on a ready/valid
// stream through a one-entry holding register.
module wishbone_classic_stream_reader
  import wishbone_classic_stream_reader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BUS_WIDTH     = 4,
  parameter int COUNT_WIDTH   = 16,
  parameter int TIMEOUT       = 255
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0]   cmd_addr,
  input  logic [COUNT_WIDTH-1:0]     cmd_count,
  output logic                       m_wb_cyc,
  output logic                       m_wb_stb,
  output logic                       m_wb_we,
  output logic [ADDRESS_WIDTH-1:0]   m_wb_addr,
  output logic [BUS_WIDTH*8-1:0]     m_wb_data_o,
  output logic [BUS_WIDTH-1:0]       m_wb_sel,
  output logic [1:0]                 m_wb_bte,
  output logic [2:0]                 m_wb_cti,
  input  logic                       m_wb_ack,
  input  logic [BUS_WIDTH*8-1:0]     m_wb_data_i,
  input  logic                       m_wb_err,
  output logic [BUS_WIDTH*8-1:0]     m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       done,
  output logic                       error
);

  localparam int ADDR_LSB = clogb2(BUS_WIDTH);
  // A TIMEOUT of 1 still needs a one-bit counter to compare against
  localparam int TIMER_W  = (TIMEOUT > 1) ? clogb2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0]       TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK  = {ADDRESS_WIDTH{1'b1}} << ADDR_LSB;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP  = ADDRESS_WIDTH'(BUS_WIDTH);

  state_t                     state_reg;
  state_t                     state_next;
  logic [ADDRESS_WIDTH-1:0]   addr_reg;
  logic [COUNT_WIDTH-1:0]     remaining_reg;
  logic [TIMER_W-1:0]         timer_reg;
  logic [BUS_WIDTH*8-1:0]     tdata_reg;
  logic                       done_reg;
  logic                       error_reg;
  logic                       timed_out;
  logic                       more_beats;

  assign timed_out  = (timer_reg == TIMER_LAST);
  assign more_beats = (remaining_reg != '0);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; ack wins over err, and bus responses only count while strobing
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid && (cmd_count != '0)) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (m_wb_ack)                   state_next = ST_HOLD;
        else if (m_wb_err || timed_out) state_next = ST_IDLE;
      end
      ST_HOLD: begin
        if (m_axis_tready) state_next = more_beats ? ST_REQ : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: address/count tracking, beat timeout, output word capture, status pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
      timer_reg     <= '0;
      tdata_reg     <= '0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_count == '0) begin
              done_reg <= 1'b1;
            end else begin
              addr_reg      <= cmd_addr & ADDR_MASK;
              remaining_reg <= cmd_count;
              timer_reg     <= '0;
            end
          end
        end
        ST_REQ: begin
          if (m_wb_ack) begin
            tdata_reg     <= m_wb_data_i;
            remaining_reg <= remaining_reg - COUNT_WIDTH'(1);
            addr_reg      <= addr_reg + ADDR_STEP;
          end else if (m_wb_err || timed_out) begin
            error_reg     <= 1'b1;
            remaining_reg <= '0;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end
        ST_HOLD: begin
          if (m_axis_tready) begin
            if (more_beats) timer_reg <= '0;
            else            done_reg  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus and stream outputs decoded from the current state
  always_comb begin
    cmd_ready     = 1'b0;
    m_wb_cyc      = 1'b0;
    m_wb_stb      = 1'b0;
    m_wb_sel      = '0;
    m_wb_cti      = CTI_CLASSIC;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state_reg)
      ST_IDLE: cmd_ready = 1'b1;
      ST_REQ: begin
        m_wb_cyc = 1'b1;
        m_wb_stb = 1'b1;
        m_wb_sel = '1;
        m_wb_cti = (remaining_reg > COUNT_WIDTH'(1)) ? CTI_INCR : CTI_END;
      end
      ST_HOLD: begin
        // cyc stays up between beats so the burst is not broken
        m_wb_cyc      = more_beats;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = !more_beats;
      end
      default: ;
    endcase
  end

  assign m_wb_we      = 1'b0;
  assign m_wb_bte     = BTE_LINEAR;
  assign m_wb_data_o  = '0;
  assign m_wb_addr    = addr_reg;
  assign m_axis_tdata = tdata_reg;
  assign done         = done_reg;
  assign error        = error_reg;

endmodule

// File: tb/tb_wishbone_classic_stream_reader.sv
// Self-checking bench for wishbone_classic_stream_reader: randomized commands,
// a modelled Wishbone responder, and queue-based scoreboards for bus beats,
// stream words and completion events.
module tb_wishbone_classic_stream_reader;

  localparam int AW = 32;
  localparam int BW = 4;
  localparam int CW = 8;
  localparam int TO = 8;
  localparam int DW = BW * 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [CW-1:0] cmd_count;
  logic          m_wb_cyc, m_wb_stb, m_wb_we;
  logic [AW-1:0] m_wb_addr;
  logic [DW-1:0] m_wb_data_o;
  logic [BW-1:0] m_wb_sel;
  logic [1:0]    m_wb_bte;
  logic [2:0]    m_wb_cti;
  logic          m_wb_ack;
  logic [DW-1:0] m_wb_data_i;
  logic          m_wb_err;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          done, error;

  wishbone_classic_stream_reader #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .COUNT_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_count(cmd_count),
    .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb), .m_wb_we(m_wb_we), .m_wb_addr(m_wb_addr),
    .m_wb_data_o(m_wb_data_o), .m_wb_sel(m_wb_sel), .m_wb_bte(m_wb_bte), .m_wb_cti(m_wb_cti),
    .m_wb_ack(m_wb_ack), .m_wb_data_i(m_wb_data_i), .m_wb_err(m_wb_err),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .done(done), .error(error)
  );

  typedef struct { logic [31:0] data; logic last; } word_t;
  typedef struct { logic [31:0] addr; logic [2:0] cti; } beat_t;
  typedef struct { bit is_err; bit is_to; bit zero; } ev_t;

  word_t word_q[$];
  beat_t beat_q[$];
  ev_t   ev_q[$];

  int chk_cnt = 0;
  int pass_cnt = 0;
  int ev_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Contents of the modelled memory at a given byte address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  // ---------------- responder and sink model ----------------
  int err_beat = -1;
  int to_beat = -1;
  bit wait_mode = 1'b0;
  int tready_mode = 0;
  int beat_idx = 0;
  int wait_ctr = 0;
  int wait_target = 0;
  int acc = 0;
  int stall = 0;
  bit spur = 1'b0;
  bit hs_bus_s = 1'b0, hs_cmd_s = 1'b0, stb_s = 1'b0, tv_hs_s = 1'b0;

  always_comb begin
    m_wb_ack = 1'b0;
    m_wb_err = 1'b0;
    if (m_wb_stb) begin
      if (!wait_mode || wait_ctr >= wait_target) begin
        if (beat_idx == err_beat) m_wb_err = 1'b1;
        else if (beat_idx != to_beat) begin
          m_wb_ack = 1'b1;
          m_wb_err = spur;
        end
      end
    end else begin
      m_wb_ack = spur;
      m_wb_err = spur;
    end
    m_wb_data_i = mem_word(m_wb_addr);
  end

  always @(negedge clk) begin
    hs_bus_s = rstn && m_wb_stb && (m_wb_ack || m_wb_err);
    hs_cmd_s = rstn && cmd_valid && cmd_ready;
    stb_s    = m_wb_stb;
    tv_hs_s  = rstn && m_axis_tvalid && m_axis_tready;
  end

  always @(posedge clk) begin
    #1;
    if (hs_cmd_s) beat_idx = 0;
    else if (hs_bus_s) beat_idx++;
    if (hs_bus_s || !stb_s) wait_ctr = 0;
    else wait_ctr++;
    if (hs_bus_s) wait_target = $urandom_range(0, 3);
    spur = 1'($urandom_range(0, 1));
    if (hs_cmd_s) begin
      acc = 0;
      stall = 0;
    end else if (tv_hs_s) acc++;
    case (tready_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = ($urandom_range(0, 3) != 0);
      2: begin
        if (acc == 1 && stall < 7) begin
          m_axis_tready = 1'b0;
          stall++;
        end else m_axis_tready = 1'b1;
      end
      default: m_axis_tready = 1'b0;
    endcase
  end

  // ---------------- monitor ----------------
  int cyc_n = 0;
  int stb_rise = 0;
  int cmd_cyc = 0;
  bit stb_prev = 1'b0;
  bit prev_tv = 1'b0;
  bit prev_tr = 1'b0;
  logic [31:0] prev_td = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      stb_prev = 1'b0;
      prev_tv = 1'b0;
      prev_tr = 1'b0;
    end else begin
      word_t w;
      beat_t b;
      ev_t e;
      cyc_n++;
      if (cmd_valid && cmd_ready) cmd_cyc = cyc_n;
      if (m_wb_stb && !stb_prev) stb_rise = cyc_n;
      stb_prev = m_wb_stb;
      if (m_wb_stb) check("stb_implies_cyc_sel", {m_wb_cyc, m_wb_sel}, {1'b1, 4'hF});
      if (m_wb_stb && (m_wb_ack || m_wb_err)) begin
        if (beat_q.size() == 0) check("beat_unexpected", 1, 0);
        else begin
          b = beat_q.pop_front();
          check("beat_addr", m_wb_addr, b.addr);
          check("beat_cti", m_wb_cti, b.cti);
          check("beat_we", m_wb_we, 0);
          $display("beat addr=%08h cti=%03b ack=%0b err=%0b", m_wb_addr, m_wb_cti, m_wb_ack, m_wb_err);
        end
      end
      if (m_axis_tvalid) begin
        check("no_stb_while_holding", m_wb_stb, 0);
        if (!m_axis_tlast) check("cyc_held_in_burst", m_wb_cyc, 1);
      end
      if (prev_tv && !prev_tr && m_axis_tvalid) check("tdata_stable", m_axis_tdata, prev_td);
      if (m_axis_tvalid && m_axis_tready) begin
        if (word_q.size() == 0) check("word_unexpected", 1, 0);
        else begin
          w = word_q.pop_front();
          check("word_data", m_axis_tdata, w.data);
          check("word_last", m_axis_tlast, w.last);
          $display("word data=%08h last=%0b", m_axis_tdata, m_axis_tlast);
        end
      end
      if (done || error) begin
        ev_seen++;
        if (ev_q.size() == 0) check("event_unexpected", 1, 0);
        else begin
          e = ev_q.pop_front();
          check("event_kind", {done, error}, e.is_err ? 2'b01 : 2'b10);
          check("event_idle", {m_wb_cyc, cmd_ready}, 2'b01);
          if (e.is_to) check("timeout_latency", cyc_n - stb_rise, TO);
          if (e.zero) check("zero_count_latency", cyc_n - cmd_cyc, 1);
          $display("event done=%0b error=%0b", done, error);
        end
      end
      prev_tv = m_axis_tvalid;
      prev_tr = m_axis_tready;
      prev_td = m_axis_tdata;
    end
  end

  // ---------------- driver ----------------
  task automatic check_reset_outputs();
    check("rst_addr", m_wb_addr, 0);
    check("rst_ctrl", {m_wb_cyc, m_wb_stb, m_wb_we, m_wb_sel, m_wb_bte, m_wb_cti,
                       m_axis_tvalid, m_axis_tlast, done, error}, 0);
    check("rst_data", {m_axis_tdata, m_wb_data_o}, 0);
    check("rst_cmd_ready", cmd_ready, 1);
  endtask

  task automatic start_cmd(input logic [31:0] a, input int cnt, input int eb, input int tob,
                           input bit wm, input int trm);
    int stop;
    ev_t ev;
    word_t w;
    beat_t b;
    logic [31:0] base;
    logic [31:0] ad;
    @(posedge clk);
    #1;
    err_beat = eb;
    to_beat = tob;
    wait_mode = wm;
    tready_mode = trm;
    stop = cnt;
    if (eb >= 0 && eb < stop) stop = eb;
    if (tob >= 0 && tob < stop) stop = tob;
    base = a & ~32'h3;
    for (int i = 0; i < cnt; i++) begin
      ad = base + 32'(i * 4);
      if (i < stop || (i == stop && i == eb)) begin
        b.addr = ad;
        b.cti = (cnt - i > 1) ? 3'b010 : 3'b111;
        beat_q.push_back(b);
      end
      if (i < stop) begin
        w.data = mem_word(ad);
        w.last = (i == cnt - 1);
        word_q.push_back(w);
      end
    end
    ev.is_err = (stop < cnt);
    ev.is_to = (stop < cnt) && (stop == tob) && (stop != eb);
    ev.zero = (cnt == 0);
    ev_q.push_back(ev);
    $display("cmd addr=%08h count=%0d err_beat=%0d timeout_beat=%0d", a, cnt, eb, tob);
    cmd_addr = a;
    cmd_count = CW'(cnt);
    cmd_valid = 1'b1;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr = $urandom;
    cmd_count = CW'($urandom);
  endtask

  task automatic run_cmd(input logic [31:0] a, input int cnt, input int eb, input int tob,
                         input bit wm, input int trm);
    int tgt;
    tgt = ev_seen + 1;
    start_cmd(a, cnt, eb, tob, wm, trm);
    for (int c = 0; c < 4000 && ev_seen < tgt; c++) @(negedge clk);
    check("cmd_completes", (ev_seen >= tgt), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int cnt, eb, tob, r;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_count = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    #2 rstn = 1'b1;

    // Directed cases
    run_cmd(32'h0000_0100, 4, -1, -1, 1'b0, 0);
    run_cmd(32'h0000_0200, 3, -1, -1, 1'b0, 2);
    run_cmd(32'h0000_0300, 0, -1, -1, 1'b0, 0);
    run_cmd(32'h0000_0400, 4, 1, -1, 1'b0, 0);
    run_cmd(32'h0000_0500, 2, -1, 0, 1'b0, 0);
    run_cmd(32'h0000_0603, 3, -1, -1, 1'b1, 1);
    run_cmd(32'hFFFF_FFF8, 4, -1, -1, 1'b0, 0);

    // Randomized commands
    for (int k = 0; k < 24; k++) begin
      a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cnt = $urandom_range(0, 6);
      eb = -1;
      tob = -1;
      r = $urandom_range(0, 9);
      if (cnt > 0 && r == 0) eb = $urandom_range(0, cnt - 1);
      else if (cnt > 0 && r == 1) tob = $urandom_range(0, cnt - 1);
      run_cmd(a, cnt, eb, tob, 1'($urandom_range(0, 1)), $urandom_range(0, 1));
    end

    // Reset while a word is being held mid-burst
    start_cmd(32'h0000_0800, 3, -1, -1, 1'b0, 3);
    for (int c = 0; c < 100 && !m_axis_tvalid; c++) @(negedge clk);
    check("hold_reached", m_axis_tvalid, 1);
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs();
    word_q.delete();
    beat_q.delete();
    ev_q.delete();
    @(posedge clk);
    #3 rstn = 1'b1;
    tready_mode = 0;
    run_cmd(32'h0000_0904, 1, -1, -1, 1'b0, 0);

    repeat (5) @(negedge clk);
    check("word_q_drained", word_q.size(), 0);
    check("beat_q_drained", beat_q.size(), 0);
    check("event_q_drained", ev_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
